// File: rtl/stack_master.sv
// stack_master: initiator for the 5-entry stack command bus (COMMAND/INDEX/IO_DATA).
// Accepts one client request at a time, enforces stack bounds locally and returns
// read data or an error flag on a one-cycle response pulse.
module stack_master #(
   parameter int unsigned DEPTH    = 5,
   parameter int unsigned DATA_W   = 4,
   parameter int unsigned IDX_W    = 3,
   parameter int unsigned READ_LAT = 1
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic [DATA_W-1:0] req_data,
   input  logic [IDX_W-1:0]  req_index,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_err,
   output logic [1:0]        COMMAND,
   output logic [IDX_W-1:0]  INDEX,
   inout  wire  [DATA_W-1:0] IO_DATA,
   output logic [IDX_W-1:0]  count,
   output logic              full,
   output logic              empty
);

   localparam int unsigned WAIT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

   localparam logic [1:0] OP_NOP  = 2'b00;
   localparam logic [1:0] OP_PUSH = 2'b01;
   localparam logic [1:0] OP_POP  = 2'b10;
   localparam logic [1:0] OP_GET  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t              r_state, w_state;
   logic [1:0]          r_op, w_op;
   logic [DATA_W-1:0]   r_wdata, w_wdata;
   logic [IDX_W-1:0]    r_rindex, w_rindex;
   logic [WAIT_W-1:0]   r_wait, w_wait;
   logic [IDX_W-1:0]    r_count, w_count;
   logic [1:0]          r_cmd, w_cmd;
   logic [IDX_W-1:0]    r_index, w_index;
   logic                r_drive, w_drive;
   logic                r_ready, w_ready;
   logic                r_rsp_valid, w_rsp_valid;
   logic [DATA_W-1:0]   r_rsp_data, w_rsp_data;
   logic                r_rsp_err, w_rsp_err;
   logic                r_full, r_empty;
   logic                w_illegal;

   // Bounds check against the occupancy at the moment of accept
   assign w_illegal = ((req_op == OP_PUSH) && (r_count == IDX_W'(DEPTH))) ||
                      ((req_op == OP_POP)  && (r_count == '0)) ||
                      ((req_op == OP_GET)  && (req_index >= r_count));

   // Master drives the data bus only during a push ISSUE cycle
   assign IO_DATA = r_drive ? r_wdata : {DATA_W{1'bz}};

   assign req_ready = r_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_data  = r_rsp_data;
   assign rsp_err   = r_rsp_err;
   assign COMMAND   = r_cmd;
   assign INDEX     = r_index;
   assign count     = r_count;
   assign full      = r_full;
   assign empty     = r_empty;

   // Next-state and next-output logic
   always_comb begin
      w_state     = r_state;
      w_op        = r_op;
      w_wdata     = r_wdata;
      w_rindex    = r_rindex;
      w_wait      = r_wait;
      w_count     = r_count;
      w_cmd       = 2'b00;
      w_index     = '0;
      w_drive     = 1'b0;
      w_ready     = 1'b0;
      w_rsp_valid = 1'b0;
      w_rsp_data  = r_rsp_data;
      w_rsp_err   = r_rsp_err;
      case (r_state)
         S_IDLE: begin
            w_ready = 1'b1;
            if (req_valid && r_ready) begin
               w_ready  = 1'b0;
               w_op     = req_op;
               w_wdata  = req_data;
               w_rindex = req_index;
               if (w_illegal || (req_op == OP_NOP)) begin
                  w_state     = S_RESP;
                  w_rsp_valid = 1'b1;
                  w_rsp_data  = '0;
                  w_rsp_err   = w_illegal;
               end else begin
                  w_state = S_ISSUE;
                  w_cmd   = req_op;
                  w_index = (req_op == OP_GET) ? req_index : '0;
                  w_drive = (req_op == OP_PUSH);
               end
            end
         end
         S_ISSUE: begin
            if (r_op == OP_PUSH) begin
               w_state     = S_RESP;
               w_count     = r_count + IDX_W'(1);
               w_rsp_valid = 1'b1;
               w_rsp_data  = '0;
               w_rsp_err   = 1'b0;
            end else begin
               w_state = S_WAIT;
               w_wait  = '0;
               w_cmd   = r_op;
               w_index = r_index;
            end
         end
         S_WAIT: begin
            w_cmd   = r_op;
            w_index = r_index;
            if (r_wait == WAIT_W'(READ_LAT - 1)) begin
               w_state     = S_RESP;
               w_cmd       = 2'b00;
               w_index     = '0;
               w_rsp_valid = 1'b1;
               w_rsp_data  = IO_DATA;
               w_rsp_err   = 1'b0;
               if (r_op == OP_POP) begin
                  w_count = r_count - IDX_W'(1);
               end
            end else begin
               w_wait = r_wait + WAIT_W'(1);
            end
         end
         S_RESP: begin
            w_state = S_IDLE;
            w_ready = 1'b1;
         end
         default: begin
            w_state = S_IDLE;
         end
      endcase
   end

   // State and output registers, synchronous reset aborts any operation
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state     <= S_IDLE;
         r_op        <= 2'b00;
         r_wdata     <= '0;
         r_rindex    <= '0;
         r_wait      <= '0;
         r_count     <= '0;
         r_cmd       <= 2'b00;
         r_index     <= '0;
         r_drive     <= 1'b0;
         r_ready     <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_rsp_err   <= 1'b0;
         r_full      <= 1'b0;
         r_empty     <= 1'b1;
      end else begin
         r_state     <= w_state;
         r_op        <= w_op;
         r_wdata     <= w_wdata;
         r_rindex    <= w_rindex;
         r_wait      <= w_wait;
         r_count     <= w_count;
         r_cmd       <= w_cmd;
         r_index     <= w_index;
         r_drive     <= w_drive;
         r_ready     <= w_ready;
         r_rsp_valid <= w_rsp_valid;
         r_rsp_data  <= w_rsp_data;
         r_rsp_err   <= w_rsp_err;
         r_full      <= (w_count == IDX_W'(DEPTH));
         r_empty     <= (w_count == '0);
      end
   end

endmodule

// File: tb/tb_stack_master.sv
// tb_stack_master: directed test of stack_master against a small behavioural stack.
`timescale 1ns/1ps
module tb_stack_master;

   logic       CLK = 1'b0;
   logic       RESET;
   logic       req_valid;
   logic       req_ready;
   logic [1:0] req_op;
   logic [3:0] req_data;
   logic [2:0] req_index;
   logic       rsp_valid;
   logic [3:0] rsp_data;
   logic       rsp_err;
   logic [1:0] COMMAND;
   logic [2:0] INDEX;
   wire  [3:0] io_data;
   logic [2:0] count;
   logic       full;
   logic       empty;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 CLK = ~CLK;

   stack_master dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_data  (req_data),
      .req_index (req_index),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .COMMAND   (COMMAND),
      .INDEX     (INDEX),
      .IO_DATA   (io_data),
      .count     (count),
      .full      (full),
      .empty     (empty)
   );

   // Behavioural stack on the far side of the bus
   logic [3:0] mem [8];
   int         sp;
   logic [1:0] prev_cmd;
   logic [3:0] stk_val;
   logic       stk_drv;

   always_comb begin
      int a;
      a = sp - 1;
      if (COMMAND == 2'b11) a = a - int'(INDEX);
      if (a < 0) a = 0;
      if (a > 7) a = 7;
      stk_val = mem[a];
      stk_drv = (COMMAND == 2'b10) || (COMMAND == 2'b11);
   end

   assign io_data = stk_drv ? stk_val : 4'bzzzz;

   always @(posedge CLK) begin
      if (RESET) begin
         sp       <= 0;
         prev_cmd <= 2'b00;
      end else begin
         prev_cmd <= COMMAND;
         if (COMMAND == 2'b01 && sp < 8) begin
            mem[sp] <= io_data;
            sp      <= sp + 1;
         end else if (COMMAND == 2'b10 && prev_cmd == 2'b10 && sp > 0) begin
            sp <= sp - 1;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Issue one request; returns at the negedge of the response cycle
   task automatic do_req(input logic [1:0] op, input logic [3:0] d, input logic [2:0] idx,
                         output logic [3:0] rd, output logic er, output int lat,
                         output logic [1:0] cmd_seen, output logic [3:0] io_seen,
                         output int rdy_bad);
      int guard;
      guard = 0; rd = 4'h0; er = 1'b0; lat = 0;
      cmd_seen = 2'b00; io_seen = 4'h0; rdy_bad = 0;
      while (!req_ready && guard < 10) begin
         @(negedge CLK);
         guard++;
      end
      req_valid = 1'b1; req_op = op; req_data = d; req_index = idx;
      @(negedge CLK);
      req_valid = 1'b0; req_op = 2'b00; req_data = 4'h0; req_index = 3'd0;
      lat = 1;
      while (lat < 10) begin
         if (COMMAND != 2'b00) cmd_seen = COMMAND;
         if (COMMAND == 2'b01) io_seen = io_data;
         if (req_ready) rdy_bad++;
         if (rsp_valid) break;
         @(negedge CLK);
         lat++;
      end
      if (!rsp_valid) lat = 99;
      rd = rsp_data;
      er = rsp_err;
   endtask

   task automatic run(input string tag, input logic [1:0] op, input logic [3:0] d,
                      input logic [2:0] idx, input logic [3:0] exp_d, input logic exp_e,
                      input int exp_lat);
      logic [3:0] rd, io_seen;
      logic       er;
      int         lat, rdy_bad;
      logic [1:0] cmd_seen;
      do_req(op, d, idx, rd, er, lat, cmd_seen, io_seen, rdy_bad);
      chk({tag, "_lat"}, lat, exp_lat);
      chk({tag, "_data"}, rd, exp_d);
      chk({tag, "_err"}, er, exp_e);
      chk({tag, "_ready_low"}, rdy_bad, 0);
      if (exp_e || op == 2'b00) chk({tag, "_no_cmd"}, cmd_seen, 2'b00);
      else                      chk({tag, "_cmd"}, cmd_seen, op);
      if (op == 2'b01 && !exp_e) chk({tag, "_io"}, io_seen, d);
   endtask

   task automatic do_reset();
      RESET = 1'b1; req_valid = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      RESET = 1'b0;
      @(negedge CLK);
   endtask

   initial begin
      logic [3:0] bb_vals [3];
      int k, pulses, rdy_resp, seen;
      RESET = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_data = 4'h0; req_index = 3'd0;
      @(negedge CLK);
      @(negedge CLK);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_command", COMMAND, 0);
      chk("rst_index", INDEX, 0);
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_ready", req_ready, 0);
      RESET = 1'b0;
      @(negedge CLK);
      chk("post_rst_ready", req_ready, 1);

      run("push3", 2'b01, 4'h3, 3'd0, 4'h0, 1'b0, 2);
      chk("cnt1", count, 1);
      run("push7", 2'b01, 4'h7, 3'd0, 4'h0, 1'b0, 2);
      run("pushA", 2'b01, 4'hA, 3'd0, 4'h0, 1'b0, 2);
      chk("cnt3", count, 3);
      run("get2", 2'b11, 4'h0, 3'd2, 4'h3, 1'b0, 3);
      run("get3_err", 2'b11, 4'h0, 3'd3, 4'h0, 1'b1, 1);
      chk("cnt3_after_get", count, 3);
      run("nop", 2'b00, 4'h0, 3'd0, 4'h0, 1'b0, 1);
      run("pop1", 2'b10, 4'h0, 3'd0, 4'hA, 1'b0, 3);
      chk("cnt2", count, 2);
      run("pop2", 2'b10, 4'h0, 3'd0, 4'h7, 1'b0, 3);
      run("pop3", 2'b10, 4'h0, 3'd0, 4'h3, 1'b0, 3);
      chk("cnt0", count, 0);
      chk("empty0", empty, 1);
      run("pop4_err", 2'b10, 4'h0, 3'd0, 4'h0, 1'b1, 1);
      chk("cnt0_after_err", count, 0);

      run("fill1", 2'b01, 4'h1, 3'd0, 4'h0, 1'b0, 2);
      run("fill2", 2'b01, 4'h2, 3'd0, 4'h0, 1'b0, 2);
      run("fill3", 2'b01, 4'h4, 3'd0, 4'h0, 1'b0, 2);
      chk("not_full4", full, 0);
      run("fill4", 2'b01, 4'h8, 3'd0, 4'h0, 1'b0, 2);
      run("fill5", 2'b01, 4'hC, 3'd0, 4'h0, 1'b0, 2);
      chk("full5", full, 1);
      chk("cnt5", count, 5);
      run("push6_err", 2'b01, 4'hF, 3'd0, 4'h0, 1'b1, 1);
      chk("cnt5_after_err", count, 5);
      run("get0_head", 2'b11, 4'h0, 3'd0, 4'hC, 1'b0, 3);
      run("get4_bottom", 2'b11, 4'h0, 3'd4, 4'h1, 1'b0, 3);
      run("get5_err", 2'b11, 4'h0, 3'd5, 4'h0, 1'b1, 1);

      // Reset while a pop is waiting on read data
      do_reset();
      run("mr_push1", 2'b01, 4'h5, 3'd0, 4'h0, 1'b0, 2);
      run("mr_push2", 2'b01, 4'h6, 3'd0, 4'h0, 1'b0, 2);
      @(negedge CLK);
      req_valid = 1'b1; req_op = 2'b10;
      @(negedge CLK);
      req_valid = 1'b0; req_op = 2'b00;
      @(negedge CLK);
      chk("mr_wait_cmd", COMMAND, 2'b10);
      RESET = 1'b1;
      @(negedge CLK);
      chk("mr_no_rsp", rsp_valid, 0);
      chk("mr_cmd0", COMMAND, 0);
      chk("mr_cnt0", count, 0);
      chk("mr_ready0", req_ready, 0);
      RESET = 1'b0;
      @(negedge CLK);
      chk("mr_ready1", req_ready, 1);
      seen = 0;
      for (int c = 0; c < 3; c++) begin
         if (rsp_valid) seen++;
         @(negedge CLK);
      end
      chk("mr_no_late_rsp", seen, 0);
      chk("mr_empty", empty, 1);

      // Back-to-back pushes with req_valid held high
      bb_vals[0] = 4'h5; bb_vals[1] = 4'h6; bb_vals[2] = 4'h9;
      k = 0; pulses = 0; rdy_resp = 0;
      req_valid = 1'b1; req_op = 2'b01;
      for (int c = 0; c < 15; c++) begin
         if (rsp_valid) begin
            pulses++;
            if (req_ready) rdy_resp++;
         end
         if (req_ready) begin
            if (k < 3) begin
               req_data = bb_vals[k];
               k++;
            end else begin
               req_valid = 1'b0;
            end
         end
         @(negedge CLK);
      end
      req_valid = 1'b0; req_op = 2'b00;
      chk("bb_pulses", pulses, 3);
      chk("bb_ready_in_resp", rdy_resp, 0);
      chk("bb_count", count, 3);
      run("bb_pop1", 2'b10, 4'h0, 3'd0, 4'h9, 1'b0, 3);
      run("bb_pop2", 2'b10, 4'h0, 3'd0, 4'h6, 1'b0, 3);
      run("bb_pop3", 2'b10, 4'h0, 3'd0, 4'h5, 1'b0, 3);
      chk("bb_empty", empty, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
